// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Command-side handshake between a client (keyboard controller logic) and
//   the PS/2 host transmitter.
//   Signals:
//     data        byte to send, sampled when send is accepted
//     send        one-cycle request strobe
//     busy        transmitter owns the bus
//     rx_inhibit  tells the scancode receiver to discard traffic
//     done        one-cycle pulse: frame sent and ACKed
//     error       one-cycle pulse: timeout or NACK
//     nack        qualifies error (1 = NACK, 0 = timeout), held until next send
//   Modports: master = client side, slave = transmitter side.
interface ps2_host_tx_if;
  logic [7:0] data;
  logic       send;
  logic       busy;
  logic       rx_inhibit;
  logic       done;
  logic       error;
  logic       nack;

  modport master (
    output data, send,
    input  busy, rx_inhibit, done, error, nack
  );

  modport slave (
    input  data, send,
    output busy, rx_inhibit, done, error, nack
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte (start, D0..D7
//   LSB first, odd parity, stop) over the open-collector clock/data pair and
//   checks the device ACK bit. Lines are only ever pulled low through the
//   active-high output enables.
//   Ports:
//     clk, rst      system clock, synchronous active-high reset
//     ps2clk_in     PS/2 clock pad input (asynchronous)
//     ps2data_in    PS/2 data pad input (asynchronous)
//     ps2clk_oe     1 = pull clock line low
//     ps2data_oe    1 = pull data line low
//     host          ps2_host_tx_if.slave command handshake
//   Optional feature macro: PS2TX_RETRY_EN
//     defined   -> a NACK or timeout restarts the same byte from the inhibit
//                  phase, up to two retries; error/nack only after the third
//                  failure.
//     undefined -> the first failure ends the transfer with error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2800,
  parameter int TIMEOUT_CYCLES = 420000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMER_W        = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2clk_in,
  input  logic         ps2data_in,
  output logic         ps2clk_oe,
  output logic         ps2data_oe,
  ps2_host_tx_if.slave host
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [TIMER_W-1:0] INH_LOAD = TIMER_W'(INHIBIT_CYCLES);
  localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAITIDLE
  } state_t;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_filt_d;
  logic          fedge;

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [10:0]         frame, frame_n;
  logic [3:0]          bitcnt, bitcnt_n;
  logic                clk_oe_q, clk_oe_n;
  logic                data_oe_q, data_oe_n;
  logic                done_q, done_n;
  logic                error_q, error_n;
  logic                nack_q, nack_n;
  logic                fail;
  logic                fail_nack;
`ifdef PS2TX_RETRY_EN
  logic [1:0]          retry_cnt, retry_n;
`endif

  // Two-flop synchroniser followed by a stability filter: the filtered value
  // only follows the synchronised line once it has differed for FILTER_LEN
  // consecutive cycles, so short glitches never reach the FSM. Everything
  // presets to 1 (idle bus) so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a     <= 2'b11;
      sync_b     <= 2'b11;
      filt       <= 2'b11;
      clk_filt_d <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        fcnt[i] <= '0;
      end
    end else begin
      sync_a     <= {ps2data_in, ps2clk_in};
      sync_b     <= sync_a;
      clk_filt_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync_b[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fedge = clk_filt_d & ~filt[0];

  // FSM state and registered outputs. Line enables are registered so a reset
  // releases both lines on the cycle after it is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      frame     <= '1;
      bitcnt    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      frame     <= frame_n;
      bitcnt    <= bitcnt_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      done_q    <= done_n;
      error_q   <= error_n;
      nack_q    <= nack_n;
    end
  end

`ifdef PS2TX_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
    end else begin
      retry_cnt <= retry_n;
    end
  end
`endif

  // Next-state logic. The frame register is never shifted; bitcnt selects
  // the bit to drive so a retry can resend the same frame unchanged.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    frame_n   = frame;
    bitcnt_n  = bitcnt;
    clk_oe_n  = clk_oe_q;
    data_oe_n = data_oe_q;
    done_n    = 1'b0;
    error_n   = 1'b0;
    nack_n    = nack_q;
    fail      = 1'b0;
    fail_nack = 1'b0;
`ifdef PS2TX_RETRY_EN
    retry_n   = retry_cnt;
`endif

    case (state)
      IDLE: begin
        // A strobe landing on the done/error cycle belongs to the old
        // transfer and is dropped.
        if (host.send && !done_q && !error_q) begin
          frame_n   = {1'b1, ~^host.data, host.data, 1'b0};
          timer_n   = INH_LOAD;
          bitcnt_n  = '0;
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
          nack_n    = 1'b0;
          state_n   = INHIBIT;
`ifdef PS2TX_RETRY_EN
          retry_n   = '0;
`endif
        end
      end

      INHIBIT: begin
        // Device edges here are our own clock pull-down; ignore them.
        if (timer == '0) begin
          data_oe_n = ~frame[0];
          clk_oe_n  = 1'b0;
          timer_n   = TO_LOAD;
          bitcnt_n  = '0;
          state_n   = SEND;
        end else begin
          timer_n = timer - 1'b1;
        end
      end

      SEND: begin
        if (fedge) begin
          data_oe_n = ~frame[bitcnt + 4'd1];
          bitcnt_n  = bitcnt + 4'd1;
          timer_n   = TO_LOAD;
          if (bitcnt == 4'd9) begin
            state_n = ACK;
          end
        end else if (timer == '0) begin
          fail = 1'b1;
        end else begin
          timer_n = timer - 1'b1;
        end
      end

      ACK: begin
        if (fedge) begin
          if (!filt[1]) begin
            timer_n = TO_LOAD;
            state_n = WAITIDLE;
          end else begin
            fail      = 1'b1;
            fail_nack = 1'b1;
          end
        end else if (timer == '0) begin
          fail = 1'b1;
        end else begin
          timer_n = timer - 1'b1;
        end
      end

      WAITIDLE: begin
        if (filt == 2'b11) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (timer == '0) begin
          fail = 1'b1;
        end else begin
          timer_n = timer - 1'b1;
        end
      end

      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
    endcase

    // Failure: either restart the frame (retry build) or release the bus
    // and report.
    if (fail) begin
`ifdef PS2TX_RETRY_EN
      if (retry_cnt != 2'd2) begin
        retry_n   = retry_cnt + 2'd1;
        timer_n   = INH_LOAD;
        bitcnt_n  = '0;
        clk_oe_n  = 1'b1;
        data_oe_n = 1'b0;
        state_n   = INHIBIT;
      end else
`endif
      begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        error_n   = 1'b1;
        nack_n    = fail_nack;
        state_n   = IDLE;
      end
    end
  end

  assign ps2clk_oe       = clk_oe_q;
  assign ps2data_oe      = data_oe_q;
  assign host.busy       = (state != IDLE);
  assign host.rx_inhibit = (state != IDLE);
  assign host.done       = done_q;
  assign host.error      = error_q;
  assign host.nack       = nack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx. A behavioural PS/2 device shares the
//   open-collector lines with the DUT, clocks the frame in, samples each bit
//   on the rising clock edge and answers with ACK or NACK. Expected bytes and
//   parity bits are hand-computed constants.
//   Honors PS2TX_RETRY_EN (three attempts before error when defined).
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 2800;
  localparam int TO   = 2000;
  localparam int FLT  = 8;
  localparam int HALF = 40;
`ifdef PS2TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2clk_oe;
  logic ps2data_oe;
  logic ps2clk_in;
  logic ps2data_in;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  ps2_host_tx_if bus ();

  // Wired-AND of host and device pull-downs.
  assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_in = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FLT),
    .TIMER_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2clk_in(ps2clk_in),
    .ps2data_in(ps2data_in),
    .ps2clk_oe(ps2clk_oe),
    .ps2data_oe(ps2data_oe),
    .host(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters so pulses landing while a device task is busy are not lost.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done === 1'b1) done_cnt++;
      if (bus.error === 1'b1) err_cnt++;
      if (bus.done === 1'b1 && bus.error === 1'b1) both_cnt++;
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.data = b;
    bus.send = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
  endtask

  // Behavioural device: waits out the inhibit, checks request-to-send, clocks
  // ten bits in (sampled on rising edges), then the ACK bit.
  task automatic device_frame(input logic ack_bit, input bit glitch, input int abort_at,
                              output logic [9:0] bits, output int inh_len,
                              output logic rts_low, output bit ok);
    int n;
    ok = 1'b1;
    bits = '0;
    inh_len = 0;
    rts_low = 1'b0;
    n = 0;
    while (ps2clk_oe !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ps2clk_oe !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    while (ps2clk_oe === 1'b1 && inh_len < 20000) begin
      @(negedge clk);
      inh_len++;
    end
    if (ps2clk_oe === 1'b1) begin
      ok = 1'b0;
      return;
    end
    rts_low = ps2data_oe;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i == abort_at) return;
      bits[i] = ps2data_in;
      if (i < 9) begin
        if (glitch) begin
          repeat (10) @(negedge clk);
          dev_clk_low = 1'b1;
          @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (HALF - 11) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
      end
    end
    repeat (10) @(negedge clk);
    dev_data_low = ~ack_bit;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst = 1'b1;
    bus.send = 1'b0;
    bus.data = 8'h00;
    repeat (4) @(negedge clk);
    obs = {ps2clk_oe, ps2data_oe, bus.busy, bus.rx_inhibit, bus.done, bus.error, bus.nack};
    vectors++;
    if (obs !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 7'b0);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_send(input logic [7:0] b, input logic par, input bit glitch,
                           input bit poke_busy, input string name);
    logic [9:0] bits;
    int inh;
    logic rts;
    bit ok;
    int d0, e0, n;
    logic [3:0] obs;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b);
    fork
      device_frame(1'b0, glitch, -1, bits, inh, rts, ok);
      begin
        if (poke_busy) begin
          repeat (600) @(negedge clk);
          bus.data = ~b;
          bus.send = 1'b1;
          @(negedge clk);
          bus.send = 1'b0;
        end
      end
    join
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_device_handshake: got %b expected 1", name, ok);
    end
    vectors++;
    if (rts !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_start_bit: got data_oe=%b expected 1", name, rts);
    end
    vectors++;
    if (inh < INH) begin
      miscompares++;
      $display("[TB] FAIL %s_inhibit_len: got %0d expected >= %0d", name, inh, INH);
    end
    vectors++;
    if (bits[7:0] !== b) begin
      miscompares++;
      $display("[TB] FAIL %s_data_bits: got %h expected %h", name, bits[7:0], b);
    end
    vectors++;
    if (bits[8] !== par) begin
      miscompares++;
      $display("[TB] FAIL %s_parity: got %b expected %b", name, bits[8], par);
    end
    vectors++;
    if (bits[9] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_stop: got %b expected 1", name, bits[9]);
    end
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("[TB] FAIL %s_done_pulses: got %0d expected 1", name, done_cnt - d0);
    end
    vectors++;
    if (err_cnt != e0) begin
      miscompares++;
      $display("[TB] FAIL %s_no_error: got %0d error pulses expected 0", name, err_cnt - e0);
    end
    obs = {bus.nack, bus.busy, ps2clk_oe, ps2data_oe};
    vectors++;
    if (obs !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_idle_after: got nack,busy,clk_oe,data_oe=%b expected 0000", name, obs);
    end
  endtask

  task automatic test_timeout();
    int n;
    int d0;
    logic [4:0] obs;
    int lo, hi;
    d0 = done_cnt;
    lo = ATTEMPTS * (INH + TO);
    hi = ATTEMPTS * (INH + TO + 2) + 20;
    send_byte(8'h5A);
    n = 0;
    while (bus.error !== 1'b1 && bus.done !== 1'b1 && n < hi + 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.error !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_error: got error=%b after %0d cycles expected 1", bus.error, n);
    end
    vectors++;
    if (n < lo || n > hi) begin
      miscompares++;
      $display("[TB] FAIL timeout_latency: got %0d expected %0d..%0d", n, lo, hi);
    end
    obs = {bus.nack, bus.busy, ps2clk_oe, ps2data_oe, bus.done};
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_state: got nack,busy,clk_oe,data_oe,done=%b expected 00000", obs);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("[TB] FAIL timeout_no_done: got %0d done pulses expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_nack();
    logic [9:0] bits;
    int inh;
    logic rts;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h5A);
    for (int a = 0; a < ATTEMPTS; a++) begin
      device_frame(1'b1, 1'b0, -1, bits, inh, rts, ok);
      vectors++;
      if (ok !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL nack_attempt%0d_handshake: got %b expected 1", a, ok);
      end
      if (a < ATTEMPTS - 1) begin
        vectors++;
        if (err_cnt != e0 || bus.busy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL nack_retry%0d: got errors=%0d busy=%b expected 0 and 1", a, err_cnt - e0, bus.busy);
        end
      end
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (err_cnt - e0 != 1) begin
      miscompares++;
      $display("[TB] FAIL nack_error_pulses: got %0d expected 1", err_cnt - e0);
    end
    vectors++;
    if (bus.nack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL nack_flag: got %b expected 1", bus.nack);
    end
    vectors++;
    if (bus.busy !== 1'b0 || ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0 || done_cnt != d0) begin
      miscompares++;
      $display("[TB] FAIL nack_idle: got busy=%b clk_oe=%b data_oe=%b done=%0d expected 0 0 0 0",
               bus.busy, ps2clk_oe, ps2data_oe, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    int inh;
    logic rts;
    bit ok;
    logic [3:0] obs;
    send_byte(8'h5A);
    device_frame(1'b0, 1'b0, 4, bits, inh, rts, ok);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_busy_before: got %b expected 1", bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    obs = {ps2clk_oe, ps2data_oe, bus.busy, bus.rx_inhibit};
    vectors++;
    if (obs !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_release: got clk_oe,data_oe,busy,rx_inhibit=%b expected 0000", obs);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits;
    int inh;
    logic rts;
    bit ok;
    int n;
    send_byte(8'hF4);
    device_frame(1'b0, 1'b0, -1, bits, inh, rts, ok);
    vectors++;
    if (bits[8:0] !== 9'h0F4) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_frame: got %h expected %h", bits[8:0], 9'h0F4);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_done: got %b expected 1", bus.done);
    end
    bus.data = 8'h12;
    bus.send = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_send_on_done_ignored: got busy=%b expected 0", bus.busy);
    end
    @(negedge clk);
    bus.send = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_next_idle_accept: got busy=%b expected 1", bus.busy);
    end
    device_frame(1'b0, 1'b0, -1, bits, inh, rts, ok);
    vectors++;
    if (bits !== 10'h312) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_frame: got %h expected %h", bits, 10'h312);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_done: got done=%b error=%b expected 1 0", bus.done, bus.error);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bus.send = 1'b0;
    bus.data = 8'h00;
    test_reset();
    test_send(8'hED, 1'b1, 1'b0, 1'b0, "send_ED");
    test_send(8'h02, 1'b0, 1'b0, 1'b0, "send_02");
    test_timeout();
    test_nack();
    test_send(8'hA5, 1'b1, 1'b0, 1'b1, "busy_ignore_A5");
    test_reset_mid();
    test_send(8'hFF, 1'b1, 1'b0, 1'b0, "after_reset_FF");
    test_send(8'h3C, 1'b1, 1'b1, 1'b0, "glitch_3C");
    test_back_to_back();
    vectors++;
    if (both_cnt != 0) begin
      miscompares++;
      $display("[TB] FAIL done_error_overlap: got %0d cycles expected 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
